// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared types, field positions and saturation helper for accel_core_p
package accel_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int ARG_HI  = 11;
    localparam int ARG_LO  = 0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_MUL   = 4'h5,
        OP_LDI   = 4'h6,
        OP_JMP   = 4'h7,
        OP_JZ    = 4'h8,
        OP_JNEG  = 4'h9,
        OP_MAX   = 4'hA,
        OP_CLR   = 4'hB,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    // Clamp a wide signed value into the signed range of a w-bit word.
    // Callers detect overflow by comparing the result with the input.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/accel_alu.sv
// rtl/accel_alu.sv - combinational ADD/SUB/MUL/MAX with saturate-or-wrap and overflow flag
module accel_alu
    import accel_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  opcode_e                   op,
    input  logic signed [DATA_W-1:0]  a,
    input  logic signed [DATA_W-1:0]  b,
    output logic signed [DATA_W-1:0]  result,
    output logic                      ovf
);

    logic signed [63:0] a_w;
    logic signed [63:0] b_w;
    logic signed [63:0] full;
    logic signed [63:0] clamped;

    // Compute the exact result at 64 bits (enough for a 32x32 product), then fit it to DATA_W.
    always_comb begin
        a_w = 64'(a);
        b_w = 64'(b);
        case (op)
            OP_ADD:  full = a_w + b_w;
            OP_SUB:  full = a_w - b_w;
            OP_MUL:  full = a_w * b_w;
            OP_MAX:  full = (a_w > b_w) ? a_w : b_w;
            default: full = a_w;
        endcase
        clamped = sat_clamp(full, DATA_W);
        ovf     = (clamped != full);
        result  = SAT_EN ? clamped[DATA_W-1:0] : full[DATA_W-1:0];
    end

endmodule

// File: rtl/accel_core_p.sv
// rtl/accel_core_p.sv - parametrised accumulator machine with host load/readback and start/done handshake
module accel_core_p
    import accel_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DMEM_DEPTH = 32,
    parameter int IMEM_DEPTH = 64,
    parameter bit SAT_EN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          ovf,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [INSTR_W-1:0]            prog_wdata,
    input  logic                          dmem_we,
    input  logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr,
    input  logic [DATA_W-1:0]             dmem_wdata,
    output logic [DATA_W-1:0]             dmem_rdata,
    output logic [DATA_W-1:0]             acc_out,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc_out
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    state_e                    state;
    state_e                    state_nxt;
    logic [IAW-1:0]            pc;
    logic signed [DATA_W-1:0]  acc;
    logic signed [DATA_W-1:0]  dmem_q;
    logic signed [DATA_W-1:0]  alu_res;
    logic                      alu_ovf;
    logic [INSTR_W-1:0]        imem_q;
    logic [INSTR_W-1:0]        instr;
    logic [INSTR_W-1:0]        imem [IMEM_DEPTH];
    logic [DATA_W-1:0]         dmem [DMEM_DEPTH];
    opcode_e                   op;
    logic                      illegal;
    logic                      host_ok;
    logic                      core_store;
    logic                      dmem_wr;
    logic [DAW-1:0]            dmem_wa;
    logic [DATA_W-1:0]         dmem_wd;
    logic [IAW-1:0]            target;

    assign op      = opcode_e'(instr[OP_HI:OP_LO]);
    assign illegal = instr[OP_HI:OP_LO] inside {4'hC, 4'hD, 4'hE};
    assign target  = instr[IAW-1:0];

    // Host access is only honoured while the core is parked; reset also drops any write in flight.
    assign host_ok    = !rst && (state == S_IDLE || state == S_HALT);
    assign core_store = !rst && (state == S_EXEC) && (op == OP_STORE);
    assign dmem_wr    = core_store || (host_ok && dmem_we);
    assign dmem_wa    = core_store ? instr[DAW-1:0] : dmem_addr;
    assign dmem_wd    = core_store ? acc : dmem_wdata;

    assign acc_out = acc;
    assign pc_out  = pc;

    accel_alu #(
        .DATA_W (DATA_W),
        .SAT_EN (SAT_EN)
    ) u_alu (
        .op     (op),
        .a      (acc),
        .b      (dmem_q),
        .result (alu_res),
        .ovf    (alu_ovf)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; every instruction walks FETCH -> DECODE -> EXEC.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                busy      = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                busy      = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy      = 1'b1;
                state_nxt = (op == OP_HALT || illegal) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
                if (start) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Architectural state: pc, accumulator and the sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= '0;
            acc <= '0;
            ovf <= 1'b0;
            err <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc  <= '0;
                        acc <= '0;
                        ovf <= 1'b0;
                        err <= 1'b0;
                    end
                end
                S_EXEC: begin
                    pc <= pc + IAW'(1);
                    case (op)
                        OP_NOP, OP_STORE: ;
                        OP_LOAD: acc <= dmem_q;
                        OP_ADD, OP_SUB, OP_MUL, OP_MAX: begin
                            acc <= alu_res;
                            ovf <= ovf | alu_ovf;
                        end
                        OP_LDI:  acc <= DATA_W'($signed(instr[ARG_HI:ARG_LO]));
                        OP_JMP:  pc <= target;
                        OP_JZ:   if (acc == '0) pc <= target;
                        OP_JNEG: if (acc[DATA_W-1]) pc <= target;
                        OP_CLR:  acc <= '0;
                        OP_HALT: pc <= pc;
                        default: begin
                            pc  <= pc;
                            err <= 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Instruction memory: host write port, synchronous read at pc during FETCH, latch in DECODE.
    always_ff @(posedge clk) begin
        if (host_ok && prog_we) begin
            imem[prog_addr] <= prog_wdata;
        end
        if (state == S_FETCH) begin
            imem_q <= imem[pc];
        end
        if (state == S_DECODE) begin
            instr <= imem_q;
        end
    end

    // Data memory: single write port shared by host and STORE; core operand read in DECODE.
    always_ff @(posedge clk) begin
        if (dmem_wr) begin
            dmem[dmem_wa] <= dmem_wd;
        end
        if (state == S_DECODE) begin
            dmem_q <= dmem[imem_q[DAW-1:0]];
        end
    end

    // Host readback register; frozen while the core runs so the host sees a stable value.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_rdata <= '0;
        end else if (!busy) begin
            dmem_rdata <= dmem[dmem_addr];
        end
    end

endmodule

// File: tb/tb_accel_core_p.sv
// tb/tb_accel_core_p.sv - scoreboard bench for accel_core_p (saturating and wrapping instances)
module tb_accel_core_p;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          prog_we = 1'b0;
    logic [5:0]    prog_addr = '0;
    logic [15:0]   prog_wdata = '0;
    logic          dmem_we = 1'b0;
    logic [4:0]    dmem_addr = '0;
    logic [DW-1:0] dmem_wdata = '0;

    logic          busy_s, done_s, err_s, ovf_s;
    logic [DW-1:0] rdata_s, acc_s;
    logic [5:0]    pc_s;
    logic          busy_w, done_w, err_w, ovf_w;
    logic [DW-1:0] rdata_w, acc_w;
    logic [5:0]    pc_w;

    accel_core_p #(.DATA_W(DW), .DMEM_DEPTH(32), .IMEM_DEPTH(64), .SAT_EN(1'b1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .busy(busy_s), .done(done_s), .err(err_s), .ovf(ovf_s),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(rdata_s),
        .acc_out(acc_s), .pc_out(pc_s)
    );

    accel_core_p #(.DATA_W(DW), .DMEM_DEPTH(32), .IMEM_DEPTH(64), .SAT_EN(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w), .done(done_w), .err(err_w), .ovf(ovf_w),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(rdata_w),
        .acc_out(acc_w), .pc_out(pc_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] acc;
        logic [DW-1:0] acc_w;
        logic          ovf;
        logic          ovf_w;
        logic          err;
        logic [5:0]    pc;
        int            lat;
        int            k;
    } run_exp_t;

    run_exp_t      run_q[$];
    logic [DW-1:0] rd_q[$];
    logic          rd_req = 1'b0;
    logic          rd_pend = 1'b0;
    logic          done_prev = 1'b0;

    always @(posedge clk) rd_pend <= rd_req;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares a run's final state when done rises, and host readback one cycle after a request.
    always @(negedge clk) begin : monitor
        run_exp_t      e;
        logic [DW-1:0] r;
        if (done_s && !done_prev) begin
            if (run_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done: got unexpected done expected none");
            end else begin
                e = run_q.pop_front();
                check("acc_sat", 64'(acc_s), 64'(e.acc));
                check("acc_wrap", 64'(acc_w), 64'(e.acc_w));
                check("ovf_sat", 64'(ovf_s), 64'(e.ovf));
                check("ovf_wrap", 64'(ovf_w), 64'(e.ovf_w));
                check("err", 64'(err_s), 64'(e.err));
                check("pc_out", 64'(pc_s), 64'(e.pc));
                check("latency", 64'(cyc - e.k), 64'(e.lat));
                check("done_wrap", 64'(done_w), 64'd1);
            end
        end
        done_prev = done_s;
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata: got unexpected read expected none");
            end else begin
                r = rd_q.pop_front();
                check("dmem_rdata_sat", 64'(rdata_s), 64'(r));
                check("dmem_rdata_wrap", 64'(rdata_w), 64'(r));
            end
        end
    end

    task automatic pwrite(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic dwrite(input logic [4:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d;
        @(negedge clk);
        dmem_we = 1'b0;
    endtask

    task automatic dread(input logic [4:0] a, input logic [DW-1:0] exp);
        @(negedge clk);
        dmem_addr = a; rd_req = 1'b1; rd_q.push_back(exp);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Same-cycle host write and read of one address; the read must return the old word.
    task automatic dwrite_read(input logic [4:0] a, input logic [DW-1:0] d, input logic [DW-1:0] old);
        @(negedge clk);
        dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d; rd_req = 1'b1; rd_q.push_back(old);
        @(negedge clk);
        dmem_we = 1'b0; rd_req = 1'b0;
    endtask

    task automatic load_prog(input logic [15:0] p[$]);
        foreach (p[i]) pwrite(6'(i), p[i]);
    endtask

    // Start a run and wait (bounded) for done; optionally poke host ports mid-run.
    task automatic run(input logic [DW-1:0] acc, input logic [DW-1:0] accw, input logic ov,
                       input logic ovw, input logic er, input logic [5:0] pc, input int lat,
                       input bit inject);
        run_exp_t e;
        int       n;
        @(negedge clk);
        start = 1'b1;
        e.acc = acc; e.acc_w = accw; e.ovf = ov; e.ovf_w = ovw; e.err = er;
        e.pc = pc; e.lat = lat; e.k = cyc;
        run_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done_s && n < 400) begin
            if (inject && cyc == e.k + 10) begin
                dmem_we = 1'b1; dmem_addr = 5'd0; dmem_wdata = 16'd99;
                prog_we = 1'b1; prog_addr = 6'd5; prog_wdata = 16'hC000;
                start = 1'b1;
            end else begin
                dmem_we = 1'b0; prog_we = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        dmem_we = 1'b0; prog_we = 1'b0; start = 1'b0;
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got no done expected done within 400 cycles");
            if (run_q.size() > 0) e = run_q.pop_back();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_s), 64'd0);
        check("rst_done", 64'(done_s), 64'd0);
        check("rst_err", 64'(err_s), 64'd0);
        check("rst_ovf", 64'(ovf_s), 64'd0);
        check("rst_acc", 64'(acc_s), 64'd0);
        check("rst_pc", 64'(pc_s), 64'd0);
        check("rst_rdata", 64'(rdata_s), 64'd0);
        rst = 1'b0;

        // Sum of four words into DMEM[4].
        dwrite(5'd0, 16'd5);
        dwrite(5'd1, 16'hFFFD);
        dwrite(5'd2, 16'd10);
        dwrite(5'd3, 16'd7);
        load_prog('{16'h1000, 16'h3001, 16'h3002, 16'h3003, 16'h2004, 16'hF000});
        run(16'd19, 16'd19, 1'b0, 1'b0, 1'b0, 6'd5, 19, 1'b0);
        dread(5'd4, 16'd19);

        // 30000 + 10000: clamps to 32767 or wraps to -25536.
        dwrite(5'd0, 16'd30000);
        dwrite(5'd1, 16'd10000);
        load_prog('{16'h1000, 16'h3001, 16'hF000});
        run(16'h7FFF, 16'h9C40, 1'b1, 1'b1, 1'b0, 6'd2, 10, 1'b0);

        // 300 * 300 = 90000: clamps to 32767 or wraps to 24464.
        dwrite(5'd2, 16'd300);
        load_prog('{16'h612C, 16'h5002, 16'hF000});
        run(16'h7FFF, 16'h5F90, 1'b1, 1'b1, 1'b0, 6'd2, 10, 1'b0);

        // Countdown loop with host writes and start attempted mid-run.
        dwrite(5'd1, 16'd1);
        load_prog('{16'h6005, 16'h4001, 16'h8004, 16'h7001, 16'h2002, 16'hF000});
        run(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 6'd5, 52, 1'b1);
        dread(5'd2, 16'd0);
        dread(5'd0, 16'd30000);

        // LDI -1, JNEG to an illegal opcode at 3.
        load_prog('{16'h6FFF, 16'h9003, 16'hF000, 16'hC000});
        run(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 6'd3, 10, 1'b0);
        pwrite(6'd3, 16'hF000);
        run(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 6'd3, 10, 1'b0);

        // Reset during the EXEC of a STORE drops the write.
        dwrite(5'd6, 16'd11);
        load_prog('{16'h6007, 16'h2006, 16'hF000});
        @(negedge clk);
        start = 1'b1;
        k0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_cycle", 64'(cyc - k0), 64'd6);
        check("pre_rst_busy", 64'(busy_s), 64'd1);
        check("pre_rst_acc", 64'(acc_s), 64'd7);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy_s), 64'd0);
        check("midrst_done", 64'(done_s), 64'd0);
        check("midrst_acc", 64'(acc_s), 64'd0);
        check("midrst_pc", 64'(pc_s), 64'd0);
        rst = 1'b0;
        dread(5'd6, 16'd11);

        // Same program from IDLE completes the store.
        run(16'd7, 16'd7, 1'b0, 1'b0, 1'b0, 6'd2, 10, 1'b0);
        dread(5'd6, 16'd7);

        dwrite(5'd7, 16'd42);
        dwrite_read(5'd7, 16'd55, 16'd42);
        dread(5'd7, 16'd55);

        repeat (3) @(negedge clk);
        check("run_q_drained", 64'(run_q.size()), 64'd0);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accel_core_p.md
Name: accel_core_p

Overview:
- Parametrised successor to the 32-word accelerator: single-issue accumulator machine with its own instruction memory (IMEM) and data memory (DMEM).
- Generalised data width and memory depths; optional saturating arithmetic.
- Adds a host load/readback port, start/busy/done handshake and an error flag, so benches and the SoC no longer poke memories hierarchically.
- Sits under the SoC host bus as a standalone compute block.

Parameters:
DATA_W, 16, signed data/accumulator width (4..32)
DMEM_DEPTH, 32, DMEM words (power of 2, <=4096)
IMEM_DEPTH, 64, IMEM words (power of 2, <=4096)
SAT_EN, 1, 1 = ADD/SUB/MUL saturate; 0 = two's-complement wrap

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin execution at pc=0; sampled in IDLE or HALT only
busy  out  1  high in FETCH/DECODE/EXEC
done  out  1  high in HALT
err  out  1  illegal opcode hit; valid while done
ovf  out  1  sticky overflow (saturated or wrapped) since last start
prog_we  in  1  IMEM write strobe (host)
prog_addr  in  $clog2(IMEM_DEPTH)  IMEM write address
prog_wdata  in  16  instruction word
dmem_we  in  1  DMEM write strobe (host)
dmem_addr  in  $clog2(DMEM_DEPTH)  DMEM host address
dmem_wdata  in  DATA_W  DMEM host write data
dmem_rdata  out  DATA_W  DMEM read data; 1-cycle latency
acc_out  out  DATA_W  accumulator
pc_out  out  $clog2(IMEM_DEPTH)  program counter

Behaviour:
- Reset: state=IDLE; acc, pc, busy, done, err, ovf, dmem_rdata = 0. Memory contents are not cleared.
- Instruction format: [15:12] opcode, [11:0] operand.
  - Address operands use their low address bits (modulo depth).
  - LDI sign-extends the 12-bit immediate to DATA_W.
- Opcodes:
  - 0 NOP
  - 1 LOAD: acc=M[a]
  - 2 STORE: M[a]=acc
  - 3 ADD: acc+=M[a]
  - 4 SUB: acc-=M[a]
  - 5 MUL: acc=acc*M[a]; full product, then saturate or truncate to DATA_W
  - 6 LDI: acc=imm
  - 7 JMP: pc=a
  - 8 JZ: if acc==0, pc=a
  - 9 JNEG: if acc<0, pc=a
  - A MAX: acc=max(acc,M[a]), signed
  - B CLR: acc=0
  - F HALT
  - C/D/E illegal
- FSM: IDLE -> FETCH -> DECODE -> EXEC -> FETCH...
  - FETCH: IMEM read at pc.
  - DECODE: latch instruction; DMEM read at operand.
  - EXEC: update acc/pc/DMEM.
  - Every instruction takes exactly 3 cycles.
- start in IDLE at cycle k: pc=0, ovf=0, err=0, acc=0; FETCH occurs at k+1.
- HALT/illegal in EXEC -> state HALT next cycle.
  - done=1 and busy=0; pc_out holds the halting instruction's address.
  - err=1 only for illegal opcodes.
  - start in HALT restarts exactly as from IDLE.
- pc increments modulo IMEM_DEPTH; running off the end wraps to 0.
- Overflow:
  - SAT_EN=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - SAT_EN=0: wrap.
  - Both modes set ovf (sticky).
- Host ports while busy:
  - prog_we and dmem_we are ignored.
  - dmem_rdata holds its last value.
  - start is ignored.
- Host ports in IDLE/HALT: same-cycle host write and read to one address returns the old data.
- STORE in EXEC followed by LOAD of the same address: the LOAD's DECODE read occurs after the write and sees the new value.
- rst mid-run: returns to IDLE within 1 cycle; an in-flight STORE is dropped.

Decomposition:
- Package accel_pkg holds:
  - opcode enum
  - FSM state enum
  - INSTR_W=16
  - opcode/operand field positions
  - sat_clamp function, parametrised by width
- One combinational sub-module, accel_alu: ADD/SUB/MUL/MAX plus saturation, outputs result and ovf.
- The core holds the FSM, pc, accumulator and both memories (inferred RAM, synchronous read).

Test Plan:
- Sum: DMEM[0..3]=5,-3,10,7; program LOAD0, ADD1, ADD2, ADD3, STORE4, HALT; start at cycle k -> done=1 at k+19; host read DMEM[4]=19; err=0; ovf=0.
- Saturation: DMEM0=30000, DMEM1=10000; LOAD0, ADD1, HALT -> SAT_EN=1: acc=32767, ovf=1; SAT_EN=0: acc=-25536, ovf=1. MUL 300*300 with SAT_EN=1 -> 32767.
- Loop: LDI 5; loop: SUB1 (DMEM1=1); JZ end; JMP loop; end: STORE2; HALT -> DMEM[2]=0, done=1.
- Illegal: opcode 0xC at IMEM[3] -> done=1, err=1, pc_out=3; a subsequent start clears err and reruns.
- Busy protection: dmem_we writes 99 to DMEM[0] mid-run -> ignored (DMEM[0] unchanged); start mid-run ignored.
- Reset mid-run: assert rst during an EXEC of STORE -> IDLE next cycle, busy=0, acc=0, target word unchanged.
